pool_window_gather: RTL and testbench
=====================================

Name: pool_window_gather

Overview:
- Upstream producer for the mean-pooling block: turns a raster-order pixel stream into complete, non-overlapping POOL_DIM x POOL_DIM neighbourhoods.
- Emits one neighbourhood per cycle on nh_vector, in the exact packing the pooling adder tree consumes.
- Sits between the convolution/activation output stream and the pooling stage.
- The pooling stage has no stall, so this block never needs backpressure.

Parameters:
- NN_WIDTH, 8: bits per pixel/element.
- POOL_DIM, 2: window side. Neighbourhood size NH = POOL_DIM*POOL_DIM.
- IMG_WIDTH, 28: pixels per row. Must be ≥ POOL_DIM.
- IMG_HEIGHT, 28: rows per frame. Must be ≥ POOL_DIM.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pixel_in  in  NN_WIDTH  pixel data.
- pixel_valid  in  1  pixel_in is accepted on this edge; always accepted.
- pixel_sof  in  1  qualified by pixel_valid; marks the frame's first pixel.
- nh_vector  out  NH*NN_WIDTH  completed window. Element j = window row j/POOL_DIM, column j%POOL_DIM, at bits [NN_WIDTH*j +: NN_WIDTH].
- nh_valid  out  1  one-cycle strobe; nh_vector is valid this cycle.
- frame_done  out  1  one-cycle strobe after the last pixel of a frame is accepted.

Behaviour:
- Reset (async, active-low): nh_vector=0, nh_valid=0, frame_done=0, col=0, row=0, all window slots=0.
- Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) advance only on accepted pixels.
  - col wraps to 0 and increments row.
  - row wraps to 0 after the last row; a new frame starts implicitly.
- Storage: W = IMG_WIDTH/POOL_DIM window registers, each NH*NN_WIDTH wide.
  - An accepted pixel with col < W*POOL_DIM and row < (IMG_HEIGHT/POOL_DIM)*POOL_DIM is written into window register col/POOL_DIM.
  - Slot index = (row%POOL_DIM)*POOL_DIM + col%POOL_DIM.
- Emission: when the accepted pixel fills the bottom-right slot (row%P==P-1 and col%P==P-1, both in range):
  - Next cycle: nh_valid=1 and nh_vector = that register's contents with the current pixel merged in.
  - Latency is exactly 1 cycle from the accepting edge. The pixel is never read back from storage first.
  - nh_vector holds its value until the next emission; nh_valid is 0 otherwise.
- Edge remainder: columns ≥ W*POOL_DIM and rows ≥ (IMG_HEIGHT/POOL_DIM)*POOL_DIM are accepted for counting but discarded. No window is emitted for them.
- Stale data: slots are overwritten before reuse, so no clear is needed between window bands.
- frame_done: asserted 1 cycle after the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted.
  - Coincides with nh_valid when that pixel completes a window.
- pixel_sof with pixel_valid: the pixel is treated as (0,0) regardless of counter state.
  - Partially filled windows are abandoned; no emission for them.
  - frame_done is not raised for the truncated frame.
- Gaps: idle cycles (pixel_valid=0) are allowed anywhere and change no state.
- Reset mid-frame: all state is cleared immediately; the next accepted pixel is (0,0).

Optional Feature:
- Macro: POOL_WIN_INDEX_EN.
- Defined: adds output nh_index [clog2(W*(IMG_HEIGHT/POOL_DIM))-1:0].
  - Registered alongside nh_vector; raster index of the emitted window.
  - Reset 0; wraps to 0 at each new frame or sof.
- Undefined: port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared parameter header (network_params.h): NN_WIDTH/NN_BITWIDTH, POOL_DIM, NEIGHBORHOOD_SIZE, NH_VECTOR_BITWIDTH, IMG_WIDTH, IMG_HEIGHT, derived W.
  - These must agree with the pooling stage's definitions.
- Sub-module pool_window_regfile: W window registers with a slot-granular write port (window index, slot index, data).
  - Asynchronous read of the addressed window.
  - Async active-low reset.
- Top level owns the counters, emission logic and strobes.

Test Plan (NN_WIDTH=8, POOL_DIM=2, 4x4 image unless stated; pixels 0..15 in raster order, one per cycle):
- Basic frame: sof on pixel 0.
  - Emissions 1 cycle after pixels 5, 7, 13, 15: nh_vector = 0x05040100, 0x07060302, 0x0D0C0908, 0x0F0E0B0A.
  - frame_done is co-incident with the last emission.
- Gapped input: same frame with pixel_valid low for 3 cycles after every pixel.
  - Identical vectors; each emission 1 cycle after its completing pixel.
- 5x5 frame, pixels 0..24: exactly 4 windows, the first 0x06050100 and the last 0x12110D0C.
  - Column 4 and row 4 are dropped.
  - frame_done 1 cycle after pixel 24.
- sof resync: 4x4 frame, then sof asserted mid-frame on pixel 6.
  - Pixels before 6 produce nothing further.
  - Data 0..15 from the sof yields the four basic-frame vectors.
  - No frame_done for the aborted frame.
- Reset mid-frame: assert reset after pixel 9.
  - All outputs are 0 asynchronously.
  - After release, a fresh frame reproduces the basic results.
- Back-to-back frames without sof: second frame values 16..31 give first window 0x15141110.
  - With POOL_WIN_INDEX_EN, nh_index sequences 0,1,2,3,0,1,2,3.

Source files
------------

// File: rtl/pool_window_gather_pkg.sv
// Shared geometry for the pooling front end: default network dimensions and the
// helpers that size counters and indices from them.
package pool_window_gather_pkg;

  localparam int NN_WIDTH_DEF   = 8;
  localparam int POOL_DIM_DEF   = 2;
  localparam int IMG_WIDTH_DEF  = 28;
  localparam int IMG_HEIGHT_DEF = 28;

  // Bits needed to address n items (at least one bit).
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to hold the value n itself, so limits compare without truncation.
  function automatic int cnt_bits(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

  function automatic int num_windows(input int img_width, input int pool_dim);
    return img_width / pool_dim;
  endfunction

  function automatic int num_bands(input int img_height, input int pool_dim);
    return img_height / pool_dim;
  endfunction

endpackage

// File: rtl/pool_window_regfile.sv
// Bank of window registers, one per horizontal window position, each holding a full
// POOL_DIM x POOL_DIM neighbourhood; written one slot at a time, read combinationally.
module pool_window_regfile
  import pool_window_gather_pkg::*;
#(
  parameter int NN_WIDTH = NN_WIDTH_DEF,
  parameter int POOL_DIM = POOL_DIM_DEF,
  parameter int NUM_WIN  = 14,
  localparam int NH        = POOL_DIM * POOL_DIM,
  localparam int VEC_W     = NH * NN_WIDTH,
  localparam int WIN_BITS  = idx_bits(NUM_WIN),
  localparam int SLOT_BITS = idx_bits(NH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en_i,
  input  logic [WIN_BITS-1:0]  wr_win_i,
  input  logic [SLOT_BITS-1:0] wr_slot_i,
  input  logic [NN_WIDTH-1:0]  wr_data_i,
  input  logic [WIN_BITS-1:0]  rd_win_i,
  output logic [VEC_W-1:0]     rd_data_o
);

  logic [VEC_W-1:0] win_q [NUM_WIN];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        win_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      win_q[wr_win_i][wr_slot_i*NN_WIDTH +: NN_WIDTH] <= wr_data_i;
    end
  end

  assign rd_data_o = win_q[rd_win_i];

endmodule

// File: rtl/pool_window_gather.sv
// Gathers a raster pixel stream into non-overlapping POOL_DIM x POOL_DIM windows for the
// pooling stage. Defining POOL_WIN_INDEX_EN adds the nh_index output (raster window index).
module pool_window_gather
  import pool_window_gather_pkg::*;
#(
  parameter int NN_WIDTH   = NN_WIDTH_DEF,
  parameter int POOL_DIM   = POOL_DIM_DEF,
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  localparam int NH        = POOL_DIM * POOL_DIM,
  localparam int VEC_W     = NH * NN_WIDTH,
  localparam int NUM_WIN   = num_windows(IMG_WIDTH, POOL_DIM),
  localparam int NUM_BANDS = num_bands(IMG_HEIGHT, POOL_DIM),
  localparam int IDX_BITS  = idx_bits(NUM_WIN * NUM_BANDS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NN_WIDTH-1:0] pixel_in,
  input  logic                pixel_valid,
  input  logic                pixel_sof,
  output logic [VEC_W-1:0]    nh_vector,
  output logic                nh_valid,
  output logic                frame_done
`ifdef POOL_WIN_INDEX_EN
  ,
  output logic [IDX_BITS-1:0] nh_index
`endif
);

  localparam int USED_COLS = NUM_WIN * POOL_DIM;
  localparam int USED_ROWS = NUM_BANDS * POOL_DIM;
  localparam int COL_BITS  = cnt_bits(IMG_WIDTH);
  localparam int ROW_BITS  = cnt_bits(IMG_HEIGHT);
  localparam int WIN_BITS  = idx_bits(NUM_WIN);
  localparam int SLOT_BITS = idx_bits(NH);

  logic [COL_BITS-1:0]  col_q, col_d, col_eff, col_ph;
  logic [ROW_BITS-1:0]  row_q, row_d, row_eff, row_ph;
  logic [VEC_W-1:0]     nh_vector_q, nh_vector_d;
  logic                 nh_valid_q, nh_valid_d;
  logic                 frame_done_q, frame_done_d;
  logic                 col_last, row_last, in_range, wr_en, emit;
  logic [WIN_BITS-1:0]  win_sel;
  logic [SLOT_BITS-1:0] slot_sel;
  logic [VEC_W-1:0]     rd_data, merged;

  // A start-of-frame pixel is placed at (0,0) no matter where the counters are.
  always_comb begin
    col_eff  = pixel_sof ? '0 : col_q;
    row_eff  = pixel_sof ? '0 : row_q;
    col_ph   = col_eff % COL_BITS'(POOL_DIM);
    row_ph   = row_eff % ROW_BITS'(POOL_DIM);
    col_last = (col_eff == COL_BITS'(IMG_WIDTH - 1));
    row_last = (row_eff == ROW_BITS'(IMG_HEIGHT - 1));
    in_range = (col_eff < COL_BITS'(USED_COLS)) && (row_eff < ROW_BITS'(USED_ROWS));
    win_sel  = WIN_BITS'(col_eff / COL_BITS'(POOL_DIM));
    slot_sel = SLOT_BITS'(row_ph) * SLOT_BITS'(POOL_DIM) + SLOT_BITS'(col_ph);
    wr_en    = pixel_valid && in_range;
    emit     = wr_en && (col_ph == COL_BITS'(POOL_DIM - 1))
                     && (row_ph == ROW_BITS'(POOL_DIM - 1));
  end

  pool_window_regfile #(
    .NN_WIDTH (NN_WIDTH),
    .POOL_DIM (POOL_DIM),
    .NUM_WIN  (NUM_WIN)
  ) u_regfile (
    .clock     (clock),
    .reset     (reset),
    .wr_en_i   (wr_en),
    .wr_win_i  (win_sel),
    .wr_slot_i (slot_sel),
    .wr_data_i (pixel_in),
    .rd_win_i  (win_sel),
    .rd_data_o (rd_data)
  );

  // The completing pixel bypasses storage so the window leaves one cycle after acceptance.
  always_comb begin
    merged = rd_data;
    merged[slot_sel*NN_WIDTH +: NN_WIDTH] = pixel_in;
  end

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    nh_vector_d  = nh_vector_q;
    nh_valid_d   = 1'b0;
    frame_done_d = 1'b0;
    if (pixel_valid) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_eff + ROW_BITS'(1);
      end else begin
        col_d = col_eff + COL_BITS'(1);
        row_d = row_eff;
      end
      nh_valid_d   = emit;
      frame_done_d = col_last && row_last;
      if (emit) begin
        nh_vector_d = merged;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_q        <= '0;
      row_q        <= '0;
      nh_vector_q  <= '0;
      nh_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      nh_vector_q  <= nh_vector_d;
      nh_valid_q   <= nh_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign nh_vector  = nh_vector_q;
  assign nh_valid   = nh_valid_q;
  assign frame_done = frame_done_q;

`ifdef POOL_WIN_INDEX_EN
  logic [IDX_BITS-1:0] nh_index_q, nh_index_d;
  logic [ROW_BITS-1:0] band;

  // Index comes straight from the window position, so it restarts at 0 with every frame.
  always_comb begin
    band       = row_eff / ROW_BITS'(POOL_DIM);
    nh_index_d = nh_index_q;
    if (emit) begin
      nh_index_d = IDX_BITS'(band) * IDX_BITS'(NUM_WIN) + IDX_BITS'(win_sel);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      nh_index_q <= '0;
    end else begin
      nh_index_q <= nh_index_d;
    end
  end

  assign nh_index = nh_index_q;
`endif

endmodule

// File: tb/tb_pool_window_gather.sv
// Bench for pool_window_gather: a 4x4 and a 5x5 instance driven from directed frames and
// random traffic, checked against an image-buffer model through expected-event queues.
module tb_pool_window_gather;
  import pool_window_gather_pkg::*;

  localparam int P     = 2;
  localparam int IDX_W = idx_bits((4 / P) * (4 / P));
  localparam int EW    = 42;  // {frame_done, nh_valid, index[7:0], vector[31:0]}

  logic        clock, rst_n;
  logic [7:0]  p4, p5;
  logic        v4, v5, s4, s5;
  logic [31:0] vec4, vec5;
  logic        nv4, nv5, fd4, fd5;
  logic [IDX_W-1:0] ix4, ix5;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [EW-1:0] exp_q0[$], exp_q1[$];
  int            cyc_q0[$], cyc_q1[$];

  int         pr[2], pc[2];
  logic [7:0] fb[2][8][8];

  pool_window_gather #(.NN_WIDTH(8), .POOL_DIM(P), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_dut4 (
    .clock(clock), .reset(rst_n), .pixel_in(p4), .pixel_valid(v4), .pixel_sof(s4),
    .nh_vector(vec4), .nh_valid(nv4), .frame_done(fd4)
`ifdef POOL_WIN_INDEX_EN
    , .nh_index(ix4)
`endif
  );

  pool_window_gather #(.NN_WIDTH(8), .POOL_DIM(P), .IMG_WIDTH(5), .IMG_HEIGHT(5)) u_dut5 (
    .clock(clock), .reset(rst_n), .pixel_in(p5), .pixel_valid(v5), .pixel_sof(s5),
    .nh_vector(vec5), .nh_valid(nv5), .frame_done(fd5)
`ifdef POOL_WIN_INDEX_EN
    , .nh_index(ix5)
`endif
  );

`ifndef POOL_WIN_INDEX_EN
  assign ix4 = '0;
  assign ix5 = '0;
`endif

  // Clock and cycle counter
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic cmp(input string name, input int d, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s dut%0d: got 0x%0h required 0x%0h (cycle %0d)", name, d, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      pr[d] = 0;
      pc[d] = 0;
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) fb[d][r][c] = 8'h00;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      v4 = 1'b0; v5 = 1'b0; s4 = 1'b0; s5 = 1'b0;
    end
  endtask

  // Driver: presents one pixel and records any window / frame_done it must produce.
  task automatic send(input int d, input logic [7:0] pix, input bit sof);
    int r, c, wd, hd;
    bit em, fdn;
    logic [31:0] v;
    logic [EW-1:0] e;
    @(negedge clock);
    v4 = 1'b0; v5 = 1'b0; s4 = 1'b0; s5 = 1'b0;
    if (d == 0) begin p4 = pix; v4 = 1'b1; s4 = sof; end
    else        begin p5 = pix; v5 = 1'b1; s5 = sof; end
    wd = (d == 0) ? 4 : 5;
    hd = wd;
    r = sof ? 0 : pr[d];
    c = sof ? 0 : pc[d];
    fb[d][r][c] = pix;
    em  = (r % P == P - 1) && (c % P == P - 1) && (c < (wd / P) * P) && (r < (hd / P) * P);
    fdn = (r == hd - 1) && (c == wd - 1);
    if (em || fdn) begin
      v = '0;
      if (em)
        for (int j = 0; j < P * P; j++) v[8*j +: 8] = fb[d][r - P + 1 + j / P][c - P + 1 + j % P];
      e = {fdn, em, 8'((r / P) * (wd / P) + c / P), v};
      if (d == 0) begin exp_q0.push_back(e); cyc_q0.push_back(cyc + 1); end
      else        begin exp_q1.push_back(e); cyc_q1.push_back(cyc + 1); end
    end
    c++;
    if (c == wd) begin
      c = 0;
      r++;
      if (r == hd) r = 0;
    end
    pr[d] = r;
    pc[d] = c;
  endtask

  task automatic send_seq(input int d, input int first, input int n, input bit sof_first, input int gap);
    for (int k = 0; k < n; k++) begin
      send(d, 8'(first + k), sof_first && (k == 0));
      if (gap > 0) idle(gap);
    end
    idle(1);
  endtask

  // Scoreboard monitor: compares each DUT output event against the queue head.
  task automatic check_out(input int d, input logic nv, input logic fd,
                           input logic [31:0] vec, input logic [7:0] idx);
    logic [EW-1:0] e;
    int ec;
    if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
      compared++;
      mismatched++;
      $display("FAIL unexpected_output dut%0d: nh_valid=%0b frame_done=%0b, none required (cycle %0d)",
               d, nv, fd, cyc);
      return;
    end
    if (d == 0) begin e = exp_q0.pop_front(); ec = cyc_q0.pop_front(); end
    else        begin e = exp_q1.pop_front(); ec = cyc_q1.pop_front(); end
    cmp("event_cycle", d, 64'(cyc), 64'(ec));
    cmp("nh_valid", d, 64'(nv), 64'(e[40]));
    cmp("frame_done", d, 64'(fd), 64'(e[41]));
    if (e[40]) begin
      cmp("nh_vector", d, 64'(vec), 64'(e[31:0]));
`ifdef POOL_WIN_INDEX_EN
      cmp("nh_index", d, 64'(idx), 64'(e[39:32]));
`endif
    end
  endtask

  always @(negedge clock) if (rst_n && (nv4 || fd4)) check_out(0, nv4, fd4, vec4, 8'(ix4));
  always @(negedge clock) if (rst_n && (nv5 || fd5)) check_out(1, nv5, fd5, vec5, 8'(ix5));

  task automatic check_zero(input string name);
    cmp({name, "_vector"}, 0, 64'(vec4), 64'h0);
    cmp({name, "_valid"}, 0, 64'(nv4), 64'h0);
    cmp({name, "_done"}, 0, 64'(fd4), 64'h0);
    cmp({name, "_index"}, 0, 64'(ix4), 64'h0);
    cmp({name, "_vector"}, 1, 64'(vec5), 64'h0);
    cmp({name, "_valid"}, 1, 64'(nv5), 64'h0);
    cmp({name, "_done"}, 1, 64'(fd5), 64'h0);
  endtask

  initial begin
    int wd, n;
    rst_n = 1'b0;
    p4 = '0; p5 = '0; v4 = 1'b0; v5 = 1'b0; s4 = 1'b0; s5 = 1'b0;
    model_reset();
    #3;
    check_zero("reset");
    @(negedge clock);
    rst_n = 1'b1;

    // Basic 4x4 frame, then the same frame with 3 idle cycles after every pixel
    send_seq(0, 0, 16, 1'b1, 0);
    idle(3);
    cmp("hold_basic", 0, 64'(vec4), 64'h0F0E0B0A);
    cmp("strobe_idle", 0, 64'(nv4), 64'h0);
    send_seq(0, 0, 16, 1'b1, 3);

    // 5x5 frame: right column and bottom row are counted but dropped
    send_seq(1, 0, 25, 1'b1, 0);
    idle(3);
    cmp("hold_5x5", 1, 64'(vec5), 64'h12110D0C);

    // Resync: sof arrives on what would be pixel 6
    send_seq(0, 0, 6, 1'b0, 0);
    send_seq(0, 0, 16, 1'b1, 0);

    // Reset in the middle of a frame
    send_seq(0, 0, 10, 1'b0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    cmp("queue_empty_at_reset", 0, 64'(exp_q0.size()), 64'h0);
    model_reset();
    @(negedge clock);
    rst_n = 1'b1;
    send_seq(0, 0, 16, 1'b0, 0);

    // Back-to-back frames with no sof
    send_seq(0, 0, 32, 1'b0, 0);
    idle(2);
    cmp("hold_b2b", 0, 64'(vec4), 64'h1F1E1B1A);

    // Random frames with random gaps and occasional sof
    for (int f = 0; f < 8; f++) begin
      int d = f % 2;
      wd = (d == 0) ? 4 : 5;
      n = wd * wd + int'($urandom_range(0, 6));
      for (int k = 0; k < n; k++) begin
        send(d, 8'($urandom_range(0, 255)), $urandom_range(0, 29) == 0);
        idle(int'($urandom_range(0, 2)));
      end
      idle(1);
    end

    // Drain outstanding expectations with a bounded wait
    for (int i = 0; i < 50 && (exp_q0.size() != 0 || exp_q1.size() != 0); i++) idle(1);
    cmp("drain", 0, 64'(exp_q0.size()), 64'h0);
    cmp("drain", 1, 64'(exp_q1.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
